wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
Shared Wishbone interconnect between the controllers (C0 = SPI1 bridge, C1 = video fetch) and the peripherals (RAM bridge, register file, keyboard). It gates each controller's strobe to that controller's timing slot and tracks a single outstanding transaction. It returns ACK and read data only to the controller that issued the strobe, and multiplexes peripheral read data by which peripheral acknowledged. It replaces the ad-hoc OR/AND glue in the top level.

Parameters:
TIMEOUT_CYCLES, 16, cycles in WAIT_ACK before the arbiter aborts the transaction (timeout feature only; legal range 2..255).

Ports:
wb_clock_i  in  1  system clock (64 MHz)
wb_reset_i  in  1  asynchronous reset, active-high
grant_strobe_i  in  1  one-cycle slot strobe from timing
c0_grant_i, c1_grant_i  in  1 each  slot owner from timing; one-hot or zero
cN_addr_i  in  WB_ADDR_WIDTH  controller N address
cN_data_i  in  DATA_WIDTH  controller N write data
cN_we_i, cN_cycle_i, cN_strobe_i  in  1 each  controller N control
cN_data_o  out  DATA_WIDTH  read data to controller N
cN_stall_o, cN_ack_o  out  1 each  to controller N
cN_err_o  out  1  timeout error to controller N (timeout feature only; tied 0 otherwise)
wb_addr_o  out  WB_ADDR_WIDTH  to peripherals
wb_data_o  out  DATA_WIDTH  write data to peripherals
wb_we_o, wb_cycle_o, wb_strobe_o  out  1 each  to peripherals
wb_stall_i  in  1  OR of peripheral stalls
sN_data_i  in  DATA_WIDTH  read data, N = 0 RAM, 1 registers, 2 keyboard
sN_ack_i  in  1  ack, N = 0..2

Behaviour:
- Reset: state = IDLE, owner = C0, timeout counter = 0. All strobe/ack/err outputs = 0, all stall outputs = 1. wb_cycle_o = 0.
- Candidate (IDLE) = granted controller: c0_grant_i wins if both grants are high (illegal; simulation assertion). In WAIT_ACK the candidate is the registered owner.
- wb_addr_o, wb_data_o and wb_we_o are a combinational mux of the candidate. wb_cycle_o = candidate cycle_i.
- IDLE: wb_strobe_o = grant_strobe_i & grant & cycle & strobe & !wb_stall_i.
  - When wb_strobe_o = 1: register owner, go to WAIT_ACK. Latency from strobe to state change is 1 cycle.
- cN_stall_o = 0 only in IDLE, when N is granted, grant_strobe_i = 1 and wb_stall_i = 0. It is 1 otherwise, including throughout WAIT_ACK. One transaction is outstanding at a time.
- WAIT_ACK: any sN_ack_i -> owner's cN_ack_o = 1 in the same cycle (combinational), with cN_data_o = data of the acking peripheral.
  - Priority if several acks are high: s0 > s1 > s2 (simulation assertion).
  - Next state IDLE. A new strobe may issue at the next granted slot strobe.
- Ack received in IDLE: dropped, no cN_ack_o (simulation assertion).
- Owner drops cycle_i in WAIT_ACK: abort, go to IDLE next cycle. An ack arriving in that same cycle is still suppressed to the owner.
- Non-owner cN_data_o = 0; non-owner ack/err = 0.
- Reset asserted mid-transaction: immediately go to the reset state. A pending ack is lost and the controller must retry.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without ack.
  - At count = TIMEOUT_CYCLES-1 with no ack: owner's cN_err_o = 1 for one cycle, return to IDLE.
  - Ack takes priority over timeout in the same cycle.
- Undefined: no counter exists, cN_err_o = 0, and WAIT_ACK waits indefinitely.

Decomposition:
- common_pkg: WB_ADDR_WIDTH and DATA_WIDTH (existing), a new wb_arb_state_t enum {IDLE, WAIT_ACK}, and WB_NUM_CONTROLLERS = 2, WB_NUM_PERIPHERALS = 3.
- Sub-module wb_read_mux: the priority ack/read-data select over the peripherals. It is purely combinational and reused by the next bus client.

Test Plan:
- C0 granted, grant_strobe pulse, c0 strobe, addr 0x00123, s0_ack 2 cycles later with data 0xA5 -> wb_strobe_o 1 cycle, c0_ack_o with c0_data_o = 0xA5, c1_ack_o = 0.
- C1 strobe while c0_grant_i active -> c1_stall_o = 1 and no wb_strobe_o. At the next c1 slot strobe the transaction issues with c1's address.
- c0 write 0x5A with wb_stall_i = 1 at the slot -> no strobe. Next slot with stall = 0 -> wb_strobe_o with wb_we_o = 1 and wb_data_o = 0x5A.
- s1_ack with 0x3C and s2_ack with 0xFF in the same cycle -> owner receives 0x3C, assertion fires.
- Abort: c0_cycle_i drops in WAIT_ACK, then a late s0_ack arrives -> no c0_ack_o, state IDLE. Reset pulse mid WAIT_ACK -> all outputs return to reset values.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> c0_err_o pulses in the 4th WAIT_ACK cycle, and the next slot accepts a new strobe.

Source files
------------

// File: rtl/common_pkg.sv
// common_pkg
// Shared bus widths and Wishbone arbiter types used across the SoC top level.
//   WB_ADDR_WIDTH       : peripheral address width
//   DATA_WIDTH          : bus data width
//   WB_NUM_CONTROLLERS  : bus masters behind the arbiter (C0 SPI1 bridge, C1 video fetch)
//   WB_NUM_PERIPHERALS  : bus slaves (0 RAM bridge, 1 register file, 2 keyboard)
package common_pkg;

    localparam int WB_ADDR_WIDTH      = 24;
    localparam int DATA_WIDTH         = 8;
    localparam int WB_NUM_CONTROLLERS = 2;
    localparam int WB_NUM_PERIPHERALS = 3;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } wb_arb_state_t;

endpackage

// File: rtl/wb_read_mux.sv
// wb_read_mux
// Combinational ack/read-data select over the peripherals. If more than one
// peripheral acknowledges at the same time, the lowest index wins.
//   ack      : per-peripheral ack
//   data     : per-peripheral read data
//   ack_any  : at least one peripheral acknowledged
//   data_sel : read data of the winning peripheral, 0 if none
module wb_read_mux
    import common_pkg::*;
(
    input  logic [WB_NUM_PERIPHERALS-1:0]                 ack,
    input  logic [WB_NUM_PERIPHERALS-1:0][DATA_WIDTH-1:0] data,
    output logic                                          ack_any,
    output logic [DATA_WIDTH-1:0]                         data_sel
);

    always_comb begin
        ack_any  = |ack;
        data_sel = '0;
        // walk downwards so the lowest acking index is the last assignment
        for (int i = WB_NUM_PERIPHERALS - 1; i >= 0; i--) begin
            if (ack[i]) begin
                data_sel = data[i];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Slot-based Wishbone arbiter between two controllers and three peripherals.
// A controller may only start a transaction on its timing slot strobe; one
// transaction is outstanding at a time and its ack / read data / error are
// routed back only to the controller that issued it.
//
// Build option: define WB_ARB_TIMEOUT_EN to abort a WAIT_ACK that sees no
// ack for TIMEOUT_CYCLES cycles and flag cN_err_o. Without it cN_err_o is 0
// and WAIT_ACK waits indefinitely.
//
// Ports:
//   wb_clock_i, wb_reset_i        : clock, async active-high reset
//   grant_strobe_i, cN_grant_i    : slot strobe and slot owner from timing
//   cN_addr_i/data_i/we_i/cycle_i/strobe_i : controller N request
//   cN_data_o/stall_o/ack_o/err_o : controller N response
//   wb_addr_o/data_o/we_o/cycle_o/strobe_o : request to peripherals
//   wb_stall_i                    : OR of peripheral stalls
//   sN_data_i, sN_ack_i           : peripheral N response
//
// state    | meaning
// IDLE     | no transaction outstanding; waiting for a granted slot strobe
// WAIT_ACK | strobe issued for owner_q; waiting for ack, abort or timeout
module wb_arbiter
    import common_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic                     grant_strobe_i,
    input  logic                     c0_grant_i,
    input  logic                     c1_grant_i,
    input  logic [WB_ADDR_WIDTH-1:0] c0_addr_i,
    input  logic [DATA_WIDTH-1:0]    c0_data_i,
    input  logic                     c0_we_i,
    input  logic                     c0_cycle_i,
    input  logic                     c0_strobe_i,
    output logic [DATA_WIDTH-1:0]    c0_data_o,
    output logic                     c0_stall_o,
    output logic                     c0_ack_o,
    output logic                     c0_err_o,
    input  logic [WB_ADDR_WIDTH-1:0] c1_addr_i,
    input  logic [DATA_WIDTH-1:0]    c1_data_i,
    input  logic                     c1_we_i,
    input  logic                     c1_cycle_i,
    input  logic                     c1_strobe_i,
    output logic [DATA_WIDTH-1:0]    c1_data_o,
    output logic                     c1_stall_o,
    output logic                     c1_ack_o,
    output logic                     c1_err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic                     wb_stall_i,
    input  logic [DATA_WIDTH-1:0]    s0_data_i,
    input  logic                     s0_ack_i,
    input  logic [DATA_WIDTH-1:0]    s1_data_i,
    input  logic                     s1_ack_i,
    input  logic [DATA_WIDTH-1:0]    s2_data_i,
    input  logic                     s2_ack_i
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

    wb_arb_state_t state_q;
    logic          owner_q;     // 0 = C0, 1 = C1

    logic [WB_NUM_PERIPHERALS-1:0]                 per_ack;
    logic [WB_NUM_PERIPHERALS-1:0][DATA_WIDTH-1:0] per_data;
    logic                                          ack_any;
    logic [DATA_WIDTH-1:0]                         ack_data;

    logic in_wait;
    logic c1_slot;      // C1 holds the slot (C0 wins an illegal double grant)
    logic grant_any;
    logic cand;
    logic cand_valid;
    logic cand_cycle;
    logic cand_strobe;
    logic slot_open;
    logic issue;
    logic deliver;
    logic abort;
    logic timeout_hit;

    assign per_ack  = {s2_ack_i, s1_ack_i, s0_ack_i};
    assign per_data = {s2_data_i, s1_data_i, s0_data_i};

    wb_read_mux u_read_mux (
        .ack      (per_ack),
        .data     (per_data),
        .ack_any  (ack_any),
        .data_sel (ack_data)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_count_q;

    assign timeout_hit = in_wait && cand_cycle && !ack_any && (wait_count_q == TIMEOUT_LAST);

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            wait_count_q <= '0;
        end else if (issue) begin
            wait_count_q <= '0;
        end else if (in_wait && !ack_any) begin
            wait_count_q <= wait_count_q + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        in_wait    = (state_q == WAIT_ACK);
        c1_slot    = !c0_grant_i && c1_grant_i;
        grant_any  = c0_grant_i || c1_grant_i;
        cand       = in_wait ? owner_q : c1_slot;
        cand_valid = in_wait || grant_any;

        wb_addr_o   = cand ? c1_addr_i : c0_addr_i;
        wb_data_o   = cand ? c1_data_i : c0_data_i;
        wb_we_o     = cand ? c1_we_i   : c0_we_i;
        cand_cycle  = cand ? c1_cycle_i  : c0_cycle_i;
        cand_strobe = cand ? c1_strobe_i : c0_strobe_i;

        // reset gating keeps the bus quiet while reset is held, whatever the
        // controllers are driving
        wb_cycle_o  = !wb_reset_i && cand_valid && cand_cycle;
        slot_open   = !wb_reset_i && !in_wait && grant_strobe_i && !wb_stall_i;
        issue       = slot_open && grant_any && cand_cycle && cand_strobe;
        wb_strobe_o = issue;

        c0_stall_o = !(slot_open && c0_grant_i);
        c1_stall_o = !(slot_open && c1_slot);

        // an owner that drops cycle_i loses any ack arriving in that cycle
        abort   = in_wait && !cand_cycle;
        deliver = in_wait && cand_cycle && ack_any;

        c0_ack_o  = deliver && !owner_q;
        c1_ack_o  = deliver &&  owner_q;
        c0_data_o = (deliver && !owner_q) ? ack_data : '0;
        c1_data_o = (deliver &&  owner_q) ? ack_data : '0;
        c0_err_o  = timeout_hit && !owner_q;
        c1_err_o  = timeout_hit &&  owner_q;
    end

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= WAIT_ACK;
                        owner_q <= cand;
                    end
                end
                WAIT_ACK: begin
                    if (abort || deliver || timeout_hit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge wb_clock_i) begin
        if (!wb_reset_i) begin
            assert (!(c0_grant_i && c1_grant_i))
                else $warning("wb_arbiter: both grants high, C0 takes the slot");
            assert ($countones(per_ack) <= 1)
                else $warning("wb_arbiter: several peripherals acked, lowest index used");
            assert (!(state_q == IDLE && ack_any))
                else $warning("wb_arbiter: ack with no transaction outstanding, dropped");
        end
    end
`endif

endmodule
